// File: rtl/fetch_queue.sv
// fetch_queue: instruction prefetch buffer between the program counter and
// instruction memory. Requests are issued only while a queue slot is
// guaranteed for the response, so no read data can ever be dropped for
// lack of space. Responses return in order and are tagged with their
// word address through a small in-flight address FIFO.
//
// Parameters
//   DEPTH    queue entries (power of two, 2..16)
//   MAX_OUT  reads in flight (1..3)
//
// Ports
//   clk, rst          clock / asynchronous active-high reset
//   pc                word address of the next instruction
//   pc_en             pc may step: the read of pc was accepted this cycle
//   flush             redirect; drops queued and in-flight instructions
//   mem_req/mem_addr  read request to instruction memory (mem_addr == pc)
//   mem_gnt           memory accepts the request
//   mem_rvalid/rdata  in-order read response
//   inst_valid/data/pc  queue head presented to decode
//   inst_ready        decode consumes the head
//
// Build option
//   FETCH_QUEUE_BYPASS_EN  when defined, a response arriving at an empty
//   queue is presented to decode in the same cycle and, if consumed,
//   never enters the queue.
module fetch_queue #(
   parameter int DEPTH   = 4,
   parameter int MAX_OUT = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] pc,
   output logic        pc_en,
   input  logic        flush,
   output logic        mem_req,
   output logic [31:0] mem_addr,
   input  logic        mem_gnt,
   input  logic        mem_rvalid,
   input  logic [31:0] mem_rdata,
   output logic        inst_valid,
   output logic [31:0] inst_data,
   output logic [31:0] inst_pc,
   input  logic        inst_ready
);

   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;                               // extra bit separates full/empty
   localparam int TW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
   localparam int OW = 2;                                    // holds 0..3
   localparam int CW = PW + 1;                               // occupancy + outstanding

   logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
   logic [OW-1:0] out_q, out_d, disc_q, disc_d;
   logic [TW-1:0] twp_q, twp_d, trp_q, trp_d;
   logic          run_q;

   logic [31:0] tag_q  [MAX_OUT];
   logic [31:0] qdat_q [DEPTH];
   logic [31:0] qpc_q  [DEPTH];

   logic [PW-1:0] occ;
   logic [CW-1:0] used;
   logic          empty, accept, rsp, keep, push, pop;
   logic          byp_show, byp_take;

   function automatic logic [TW-1:0] tnext(input logic [TW-1:0] i);
      return (i == TW'(MAX_OUT - 1)) ? '0 : i + 1'b1;
   endfunction

   assign occ   = wptr_q - rptr_q;
   assign empty = (occ == '0);
   assign used  = CW'(occ) + CW'(out_q);

   // run_q holds off the first request until the first edge after reset
   // releases, so rst never feeds the datapath directly.
   assign mem_req  = run_q && !flush && (out_q < OW'(MAX_OUT)) && (used < CW'(DEPTH));
   assign accept   = mem_req && mem_gnt;
   assign pc_en    = accept;
   assign mem_addr = pc;

   // A response with nothing outstanding is illegal and ignored.
   assign rsp  = mem_rvalid && (out_q != '0);
   assign keep = rsp && !flush && (disc_q == '0);

`ifdef FETCH_QUEUE_BYPASS_EN
   assign byp_show = keep && empty;
   assign byp_take = byp_show && inst_ready;
`else
   assign byp_show = 1'b0;
   assign byp_take = 1'b0;
`endif

   assign push = keep && !byp_take;
   assign pop  = !empty && inst_ready && !flush;

   // Outputs are forced to zero when nothing is presented so reset and
   // empty states never expose stale queue contents.
   assign inst_valid = !empty || byp_show;
   assign inst_data  = !empty  ? qdat_q[rptr_q[AW-1:0]] :
                       byp_show ? mem_rdata : 32'h0;
   assign inst_pc    = !empty  ? qpc_q[rptr_q[AW-1:0]] :
                       byp_show ? tag_q[trp_q] : 32'h0;

   always_comb begin
      wptr_d = wptr_q + PW'(push);
      rptr_d = rptr_q + PW'(pop);
      out_d  = out_q;
      disc_d = disc_q;
      twp_d  = accept ? tnext(twp_q) : twp_q;
      trp_d  = rsp    ? tnext(trp_q) : trp_q;

      if (accept && !rsp)
         out_d = out_q + 1'b1;
      else if (!accept && rsp)
         out_d = out_q - 1'b1;

      if (flush) begin
         rptr_d = wptr_q;                   // push is blocked during flush
         // Everything still in flight after this edge belongs to the old path.
         disc_d = out_q - OW'(rsp);
      end else if (rsp && disc_q != '0) begin
         disc_d = disc_q - 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wptr_q <= '0;
         rptr_q <= '0;
         out_q  <= '0;
         disc_q <= '0;
         twp_q  <= '0;
         trp_q  <= '0;
         run_q  <= 1'b0;
      end else begin
         wptr_q <= wptr_d;
         rptr_q <= rptr_d;
         out_q  <= out_d;
         disc_q <= disc_d;
         twp_q  <= twp_d;
         trp_q  <= trp_d;
         run_q  <= 1'b1;
      end
   end

   // Storage arrays need no reset: pointers and output gating cover it.
   always_ff @(posedge clk) begin
      if (accept)
         tag_q[twp_q] <= pc;
      if (push) begin
         qdat_q[wptr_q[AW-1:0]] <= mem_rdata;
         qpc_q[wptr_q[AW-1:0]]  <= tag_q[trp_q];
      end
   end

endmodule

// File: tb/tb_fetch_queue.sv
module tb_fetch_queue;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] pc;
   logic        pc_en;
   logic        flush;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic        mem_gnt;
   logic        mem_rvalid;
   logic [31:0] mem_rdata;
   logic        inst_valid;
   logic [31:0] inst_data;
   logic [31:0] inst_pc;
   logic        inst_ready;

   always #5 clk = ~clk;

   fetch_queue #(.DEPTH(4), .MAX_OUT(2)) dut (
      .clk(clk), .rst(rst), .pc(pc), .pc_en(pc_en), .flush(flush),
      .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
      .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
      .inst_valid(inst_valid), .inst_data(inst_data), .inst_pc(inst_pc),
      .inst_ready(inst_ready)
   );

`ifdef FETCH_QUEUE_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif
   localparam int FILL = BYP ? 1 : 2;   // cycles before the first instruction shows

   int errs = 0;
   int checks = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
      end
   endtask

   typedef struct {
      logic fl, gnt, rv, rdy;
      logic [31:0] rd, pc;
      logic req, pe, iv;
      logic [31:0] dat, ipc;
   } vec_t;

   function automatic vec_t mk(input logic fl, gnt, rv, rdy, input logic [31:0] rd, p,
                               input logic req, pe, iv, input logic [31:0] dat, ipc);
      vec_t v;
      v.fl = fl; v.gnt = gnt; v.rv = rv; v.rdy = rdy; v.rd = rd; v.pc = p;
      v.req = req; v.pe = pe; v.iv = iv; v.dat = dat; v.ipc = ipc;
      return v;
   endfunction

   // Called at a negedge: drive, check mid-cycle, advance to next negedge.
   task automatic apply(input vec_t v, input int k);
      flush = v.fl; mem_gnt = v.gnt; mem_rvalid = v.rv; mem_rdata = v.rd;
      inst_ready = v.rdy; pc = v.pc;
      #2;
      chk($sformatf("v%0d mem_req", k), mem_req, v.req);
      chk($sformatf("v%0d pc_en", k), pc_en, v.pe);
      chk($sformatf("v%0d inst_valid", k), inst_valid, v.iv);
      chk($sformatf("v%0d inst_data", k), inst_data, v.dat);
      chk($sformatf("v%0d inst_pc", k), inst_pc, v.ipc);
      chk($sformatf("v%0d mem_addr", k), mem_addr, v.pc);
      @(negedge clk);
   endtask

   // 1-cycle memory + PC model for the streaming sequences
   logic        last_pe, pend_v;
   logic [31:0] pend_a, exp_pc;
   logic        s_pe, s_iv, s_req;
   logic [31:0] s_ipc, s_dat, s_addr;

   function automatic logic [31:0] mdat(input logic [31:0] a);
      return a ^ 32'hC0DE_0000;
   endfunction

   task automatic cyc(input logic rdy, input logic fl, input logic gnt);
      if (last_pe) begin pend_v = 1'b1; pend_a = pc; pc = pc + 1; end
      else pend_v = 1'b0;
      inst_ready = rdy; flush = fl; mem_gnt = gnt;
      mem_rvalid = pend_v; mem_rdata = pend_v ? mdat(pend_a) : 32'h0;
      #2;
      s_pe = pc_en; s_iv = inst_valid; s_req = mem_req;
      s_ipc = inst_pc; s_dat = inst_data; s_addr = mem_addr;
      last_pe = s_pe;
      @(negedge clk);
   endtask

   task automatic take(input string nm);
      chk({nm, " pc"}, s_ipc, exp_pc);
      chk({nm, " data"}, s_dat, mdat(exp_pc));
      exp_pc = exp_pc + 1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1; flush = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0;
      mem_rdata = 32'h0; inst_ready = 1'b0;
      last_pe = 1'b0; pend_v = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
   endtask

   vec_t tbl[21];

   initial begin
      int npe, npop;
      rst = 1'b1; pc = 32'h10; flush = 1'b0; mem_gnt = 1'b1; mem_rvalid = 1'b0;
      mem_rdata = 32'h0; inst_ready = 1'b1; last_pe = 1'b0; pend_v = 1'b0;
      pend_a = 32'h0; exp_pc = 32'h0;

      //        fl gnt rv rdy rdata        pc     req pe iv  data                 ipc
      tbl[0]  = mk(0,1,0,0, 32'h0,      32'h10, 1,1,0,   32'h0,               32'h0);
      tbl[1]  = mk(0,1,1,0, 32'hA0,     32'h11, 1,1,BYP, BYP?32'hA0:32'h0,    BYP?32'h10:32'h0);
      tbl[2]  = mk(0,0,1,0, 32'hA1,     32'h12, 1,0,1,   32'hA0,              32'h10);
      tbl[3]  = mk(0,1,0,1, 32'h0,      32'h12, 1,1,1,   32'hA0,              32'h10);
      tbl[4]  = mk(0,1,0,0, 32'h0,      32'h13, 1,1,1,   32'hA1,              32'h11);
      tbl[5]  = mk(0,1,0,0, 32'h0,      32'h14, 0,0,1,   32'hA1,              32'h11);
      tbl[6]  = mk(1,1,1,1, 32'hBAD0,   32'h40, 0,0,1,   32'hA1,              32'h11);
      tbl[7]  = mk(0,1,0,1, 32'h0,      32'h40, 1,1,0,   32'h0,               32'h0);
      tbl[8]  = mk(0,1,1,1, 32'hBAD1,   32'h41, 0,0,0,   32'h0,               32'h0);
      tbl[9]  = mk(0,0,1,0, 32'hC0,     32'h41, 1,0,BYP, BYP?32'hC0:32'h0,    BYP?32'h40:32'h0);
      tbl[10] = mk(0,0,0,1, 32'h0,      32'h41, 1,0,1,   32'hC0,              32'h40);
      tbl[11] = mk(0,0,0,0, 32'h0,      32'h41, 1,0,0,   32'h0,               32'h0);
      tbl[12] = mk(0,1,0,0, 32'h0,      32'h20, 1,1,0,   32'h0,               32'h0);
      tbl[13] = mk(0,1,0,0, 32'h0,      32'h21, 1,1,0,   32'h0,               32'h0);
      tbl[14] = mk(1,1,0,0, 32'h0,      32'h21, 0,0,0,   32'h0,               32'h0);
      tbl[15] = mk(0,1,1,0, 32'hDD0,    32'h40, 0,0,0,   32'h0,               32'h0);
      tbl[16] = mk(0,1,1,0, 32'hDD1,    32'h40, 1,1,0,   32'h0,               32'h0);
      tbl[17] = mk(0,0,1,1, 32'h1234,   32'h41, 1,0,BYP, BYP?32'h1234:32'h0,  BYP?32'h40:32'h0);
      tbl[18] = mk(0,0,0,1, 32'h0,      32'h41, 1,0,!BYP,BYP?32'h0:32'h1234,  BYP?32'h0:32'h40);
      tbl[19] = mk(0,0,1,0, 32'hEEEE,   32'h41, 1,0,0,   32'h0,               32'h0);
      tbl[20] = mk(0,0,0,0, 32'h0,      32'h41, 1,0,0,   32'h0,               32'h0);

      // Reset state, with a grant offered to prove nothing is accepted
      #2;
      chk("rst mem_req", mem_req, 0);
      chk("rst pc_en", pc_en, 0);
      chk("rst inst_valid", inst_valid, 0);
      chk("rst inst_data", inst_data, 0);
      chk("rst inst_pc", inst_pc, 0);
      @(negedge clk);
      rst = 1'b0; mem_gnt = 1'b0;
      #2 chk("release-cycle mem_req", mem_req, 0);
      @(negedge clk);

      foreach (tbl[k]) apply(tbl[k], k);

      // Streaming with a 1-cycle memory
      do_reset(); pc = 32'h10; exp_pc = 32'h10;
      for (int i = 0; i < 20; i++) begin
         cyc(1'b1, 1'b0, 1'b1);
         chk($sformatf("stream pc_en c%0d", i), s_pe, 1);
         if (i >= FILL) chk($sformatf("stream valid c%0d", i), s_iv, 1);
         if (s_iv) take("stream");
      end
      chk("stream count", exp_pc, 32'h10 + 32'(20 - FILL));

      // Backpressure: exactly DEPTH reads accepted, then drain in order
      do_reset(); pc = 32'h100; exp_pc = 32'h100; npe = 0;
      for (int i = 0; i < 10; i++) begin
         cyc(1'b0, 1'b0, 1'b1);
         npe += int'(s_pe);
      end
      chk("bp accepted", npe, 4);
      chk("bp mem_req", s_req, 0);
      chk("bp valid", s_iv, 1);
      npop = 0;
      for (int i = 0; i < 30 && npop < 10; i++) begin
         cyc(1'b1, 1'b0, 1'b1);
         if (s_iv) begin take("bp drain"); npop++; end
      end
      chk("bp drained", npop, 10);

      // Asynchronous reset with 3 entries queued and 1 read in flight
      do_reset(); pc = 32'h200;
      for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 1'b1);
      #1 chk("pre-rst valid", inst_valid, 1);
      #2 rst = 1'b1; mem_rvalid = 1'b0;
      #1;
      chk("async rst valid", inst_valid, 0);
      chk("async rst req", mem_req, 0);
      chk("async rst pc_en", pc_en, 0);
      chk("async rst data", inst_data, 0);
      if (last_pe) pc = pc + 1;   // pc stepped on the last accepted edge
      last_pe = 1'b0; pend_v = 1'b0; mem_gnt = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      exp_pc = 32'h204;
      npop = 0;
      for (int i = 0; i < 10 && npop < 1; i++) begin
         cyc(1'b1, 1'b0, 1'b1);
         if (i == 0) begin
            chk("restart addr", s_addr, 32'h204);
            chk("restart pc_en", s_pe, 1);
         end
         if (s_iv) begin take("restart"); npop++; end
      end
      chk("restart popped", npop, 1);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, want completion");
      $fatal(1);
   end

endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 Parameter DEPTH, default 4, queue entries; legal values are powers of two from 2 to 16.
REQ-002 Parameter MAX_OUT, default 2, maximum memory reads in flight; legal values are 1 to 3.
REQ-003 clk  in  1  clock; all state updates on its rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 pc  in  32  word address of the next instruction, from the program counter.
REQ-006 pc_en  out  1  pulse; PC may step on this edge because the read of pc was accepted.
REQ-007 flush  in  1  redirect; discards queued and in-flight instructions.
REQ-008 mem_req  out  1  read request to instruction memory.
REQ-009 mem_addr  out  32  read address; always equal to pc.
REQ-010 mem_gnt  in  1  memory accepts the request this cycle.
REQ-011 mem_rvalid  in  1  read data valid; responses return in request order.
REQ-012 mem_rdata  in  32  instruction word.
REQ-013 inst_valid  out  1  instruction available to decode.
REQ-014 inst_data  out  32  instruction word.
REQ-015 inst_pc  out  32  word address of inst_data.
REQ-016 inst_ready  in  1  decode consumes the entry when inst_valid is also high.

Function
REQ-017 Define credit = DEPTH - occupancy - outstanding.
- mem_req = !flush && outstanding < MAX_OUT && credit > 0.
- This guarantees every accepted read has a free slot, so no response is ever dropped for lack of space.
REQ-018 A request is accepted when mem_req and mem_gnt are both high.
- pc_en = mem_req & mem_gnt.
- outstanding increments by 1.
- The address is pushed into an internal MAX_OUT-deep tag FIFO.
REQ-019 A response is a mem_rvalid pulse.
- It pops the tag FIFO and decrements outstanding.
- If the discard count is 0, {mem_rdata, tag} is written to the queue tail.
- If the discard count is nonzero, the response is dropped and the discard count decrements.
REQ-020 Simultaneous accept and response in one cycle leave outstanding unchanged; the tag FIFO pushes and pops correctly.
REQ-021 inst_valid = (occupancy != 0); inst_data and inst_pc show the queue head.
- A pop occurs on inst_valid & inst_ready.
- Push and pop in the same cycle leave occupancy unchanged, including when the queue is full.
REQ-022 Read and write pointers wrap modulo DEPTH.
- occupancy ranges 0..DEPTH; full and empty are distinguished by an extra pointer bit.
REQ-023 On flush:
- occupancy goes to 0 on the next edge.
- discard count is loaded with outstanding minus 1 if a response arrives in the flush cycle, else with outstanding.
- No request is issued in the flush cycle.
- A pop in the flush cycle is ignored.
REQ-024 A response arriving in the flush cycle is dropped.
REQ-025 Occupancy and outstanding never exceed DEPTH and MAX_OUT. mem_rvalid with outstanding == 0 is illegal; the block ignores it.

Reset
REQ-026 While rst is high:
- occupancy, outstanding, discard count and pointers are 0.
- inst_valid = 0, mem_req = 0, pc_en = 0.
- inst_data = 0, inst_pc = 0.
REQ-027 Reset mid-transfer abandons in-flight reads. The memory is reset together with this block, so no stale response follows.
REQ-028 The first mem_req is asserted in the cycle after rst deasserts.

Configuration
REQ-029 Macro FETCH_QUEUE_BYPASS_EN.
- Defined: when the queue is empty and a non-discarded response arrives, inst_valid/inst_data/inst_pc reflect it combinationally in the same cycle. If inst_ready is high, it is consumed without entering the queue.
- Undefined: every response is written to the queue first; minimum latency from mem_rvalid to inst_valid is 1 cycle.

Verification
REQ-030 Streaming: reset, pc=0x10, mem_gnt=1, 1-cycle memory, inst_ready=1 -> inst_pc = 0x10, 0x11, 0x12... with no gaps after fill; pc_en high every cycle.
REQ-031 Backpressure: inst_ready=0 for 10 cycles -> exactly DEPTH=4 entries accepted in total, then mem_req=0; inst_ready=1 -> 4 entries pop in order, then fetching resumes.
REQ-032 Flush with 2 outstanding: flush=1 at pc=0x20 -> next two mem_rvalid responses dropped; first inst_valid carries inst_pc equal to the post-flush pc, e.g. 0x40.
REQ-033 Simultaneous: queue full, pop and response in the same cycle -> occupancy stays 4, no data lost, order preserved.
REQ-034 Reset mid-operation: rst pulse with 3 queued entries -> inst_valid=0 immediately (asynchronously); after release, fetch restarts from the current pc.
REQ-035 Bypass: build with FETCH_QUEUE_BYPASS_EN, empty queue, response 0xDEADBEEF -> inst_valid=1 with inst_data=0xDEADBEEF in the same cycle; without the macro, one cycle later.
